// File: rtl/reg4_latch_write_arbiter_if.sv
// Requester and latch-side signal bundle for the 4-bit latch write arbiter.
// slave = arbiter side, master = requesters plus the latch register.
interface reg4_latch_write_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] wdata;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic                  err;
    logic                  busy;
    logic [WIDTH-1:0]      latch_S;
    logic [WIDTH-1:0]      latch_R;
    logic [WIDTH-1:0]      latch_Q;

    modport master (
        output req,
        output wdata,
        output latch_Q,
        input  gnt,
        input  done,
        input  err,
        input  busy,
        input  latch_S,
        input  latch_R
    );

    modport slave (
        input  req,
        input  wdata,
        input  latch_Q,
        output gnt,
        output done,
        output err,
        output busy,
        output latch_S,
        output latch_R
    );
endinterface

// File: rtl/reg4_latch_write_arbiter.sv
// Round-robin arbiter that writes an unclocked SR-latch register: clear, gap, set, readback check with retries.
// Latency 6*(retries+1)+1 cycles from accept to done; requests simply wait (no backpressure beyond holding req).
module reg4_latch_write_arbiter #(
    parameter int NREQ      = 4,
    parameter int WIDTH     = 4,
    parameter int PULSE_CYC = 2,
    parameter int RETRY_MAX = 3
) (
    input  logic                           clk,
    input  logic                           rst_n,
    reg4_latch_write_arbiter_if.slave      bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;
    localparam int RW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CLR  = 3'd1,
        S_GAP  = 3'd2,
        S_SET  = 3'd3,
        S_CHK  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [RW-1:0]     r_retry;
    logic [IW-1:0]     r_ptr;
    logic [IW-1:0]     r_winner;
    logic [WIDTH-1:0]  r_data;
    logic [NREQ-1:0]   r_gnt;
    logic [NREQ-1:0]   r_done;
    logic              r_err;
    logic              r_busy;
    logic [WIDTH-1:0]  r_latch_S;
    logic [WIDTH-1:0]  r_latch_R;

    logic              w_any;
    logic [IW-1:0]     w_win_idx;
    logic [NREQ-1:0]   w_win_oh;
    logic [WIDTH-1:0]  w_win_dat;
    logic              w_pulse_last;
    logic              w_readback_ok;
    logic              w_retry_left;

    // Round-robin search starts just after the last winner so no requester can starve.
    always_comb begin
        int idx;
        w_any     = 1'b0;
        w_win_idx = '0;
        w_win_oh  = '0;
        w_win_dat = '0;
        idx       = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(r_ptr) + k) % NREQ;
            if (!w_any && bus.req[idx]) begin
                w_any     = 1'b1;
                w_win_idx = IW'(idx);
                w_win_dat = bus.wdata[idx*WIDTH +: WIDTH];
            end
        end
        w_win_oh[w_win_idx] = w_any;
    end

    assign w_pulse_last  = (r_cnt == CW'(PULSE_CYC - 1));
    assign w_readback_ok = (bus.latch_Q == r_data);
    assign w_retry_left  = (r_retry != RW'(RETRY_MAX));

    // Outputs are loaded on the same edge as the state they belong to, so S and R
    // are never both driven: every transition clears one before the other is raised.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_retry   <= '0;
            r_ptr     <= IW'(NREQ - 1);
            r_winner  <= '0;
            r_data    <= '0;
            r_gnt     <= '0;
            r_done    <= '0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
            r_latch_S <= '0;
            r_latch_R <= '0;
        end else begin
            r_done <= '0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_winner  <= w_win_idx;
                        r_data    <= w_win_dat;
                        r_retry   <= '0;
                        r_cnt     <= '0;
                        r_gnt     <= w_win_oh;
                        r_busy    <= 1'b1;
                        r_latch_R <= '1;
                        r_latch_S <= '0;
                        r_state   <= S_CLR;
                    end
                end
                S_CLR: begin
                    if (w_pulse_last) begin
                        r_cnt     <= '0;
                        r_latch_R <= '0;
                        r_state   <= S_GAP;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_GAP: begin
                    r_latch_S <= r_data;
                    r_state   <= S_SET;
                end
                S_SET: begin
                    if (w_pulse_last) begin
                        r_cnt     <= '0;
                        r_latch_S <= '0;
                        r_state   <= S_CHK;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_CHK: begin
                    if (w_readback_ok) begin
                        r_done  <= r_gnt;
                        r_state <= S_DONE;
                    end else if (w_retry_left) begin
                        r_retry   <= r_retry + RW'(1);
                        r_latch_R <= '1;
                        r_state   <= S_CLR;
                    end else begin
                        r_done  <= r_gnt;
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_ptr   <= r_winner;
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_gnt     <= '0;
                    r_busy    <= 1'b0;
                    r_latch_S <= '0;
                    r_latch_R <= '0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt     = r_gnt;
    assign bus.done    = r_done;
    assign bus.err     = r_err;
    assign bus.busy    = r_busy;
    assign bus.latch_S = r_latch_S;
    assign bus.latch_R = r_latch_R;
endmodule
